// File: rtl/child_response_collector.sv
// child_response_collector: round-robin fan-in of child result words
// into a tagged FIFO, with a sticky "every child seen" flag.
module child_response_collector #(
  parameter  int NUM_CHILD  = 5,
  parameter  int DATA_W     = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDX_W      = $clog2(NUM_CHILD),
  localparam int FILL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CHILD-1:0]        child_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] child_data,
  output logic [NUM_CHILD-1:0]        child_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_idx,
  output logic [FILL_W-1:0]           fill,
  output logic                        all_seen,
  input  logic                        clear_seen
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = IDX_W + DATA_W;

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant;
  logic                 grant_found;
  logic [IDX_W:0]       sum;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic [ENT_W-1:0]     push_word;
  logic [ENT_W-1:0]     head;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [ENT_W-1:0]     mem [FIFO_DEPTH];
  logic [NUM_CHILD-1:0] seen;

  // first valid child at or after rr_ptr, wrapping modulo NUM_CHILD
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    sum         = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_CHILD))
        sum = sum - (IDX_W+1)'(NUM_CHILD);
      if (!grant_found && child_valid[sum[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant       = sum[IDX_W-1:0];
      end
    end
  end

  // ready uses registered fill only, so a full FIFO blocks even on pop
  assign full = (fill == FILL_W'(FIFO_DEPTH));
  assign child_ready = (!rst && grant_found && !full)
                     ? (NUM_CHILD'(1) << grant) : '0;
  assign push      = |child_ready;
  assign push_word = {grant, child_data[grant*DATA_W +: DATA_W]};

  assign out_valid = (fill != '0);
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_idx   = out_valid ? head[ENT_W-1 -: IDX_W] : '0;
  assign all_seen  = &seen;

  // round-robin pointer moves past the child just accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (push)
      rr_ptr <= (grant == IDX_W'(NUM_CHILD-1))
              ? '0 : grant + IDX_W'(1);
  end

  // FIFO pointers and occupancy; reset drops all contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_word;
  end

  // seen mask; a clear still records the child accepted that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      seen <= '0;
    else if (clear_seen)
      seen <= child_ready;
    else
      seen <= seen | child_ready;
  end

  a_ready_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(child_ready));
  a_fill_bound: assert property (
    @(posedge clk) disable iff (rst) fill <= FILL_W'(FIFO_DEPTH));
  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (rst) !(pop && fill == '0));
  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst) !(push && full));

endmodule
